// File: rtl/mux_nto1_arb_pkg.sv
// Shared constants and helpers for the N:1 arbitrated output mux.
package mux_nto1_arb_pkg;

  // Arbitration modes.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2, used for channel-index widths (valid for n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_arb_if.sv
// Bundle of the NCH input channels and the single output channel.
// Handshake: a beat moves on a channel in any cycle where valid && ready
// are both high at the rising clock edge; valid must not depend on ready,
// ready may depend on valid.
interface mux_nto1_arb_if
  import mux_nto1_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NCH    = 4
);
  localparam int SELW = clog2(NCH);

  logic [NCH*DWIDTH-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [DWIDTH-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_sel;

  // Producers/consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  // Arbiter/mux side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational arbiter: fixed priority (channel 0 first) or round-robin
// starting one past the last granted channel. Grants nothing when en=0.
module rr_arbiter
  import mux_nto1_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int RR   = ARB_RR,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx
);

  logic found;
  int   cand;

  // Priority search; the wrap is a compare against NCH-1 so non-power-of-two
  // channel counts never yield an out-of-range index.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NCH; k++) begin
      if (RR == ARB_RR) begin
        cand = int'(ptr) + 1 + k;
        if (cand > NCH - 1) cand = cand - NCH;
      end else begin
        cand = k;
      end
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_arb.sv
// N:1 arbitrated mux with a one-beat registered output buffer.
// One cycle latency, full throughput: the buffer refills in the cycle it drains.
module mux_nto1_arb
  import mux_nto1_arb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int NCH    = 4,
  parameter int RR     = ARB_RR,
  localparam int SELW  = clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  mux_nto1_arb_if.slave   bus,
  output logic [SELW-1:0] dbg_ptr
);

  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;

  logic [NCH-1:0]    grant;
  logic [SELW-1:0]   grant_idx;
  logic              load_en;
  logic              arb_en;
  logic              xfer_in;

  // Buffer can take a beat when empty or when it is being drained this cycle;
  // no channel is offered ready while reset is held.
  assign load_en = !out_valid_q || bus.out_ready;
  assign arb_en  = load_en && !rst;

  rr_arbiter #(
    .NCH (NCH),
    .RR  (RR)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A grant only exists for a valid channel, so any grant is a transfer.
  assign bus.in_ready = grant;
  assign xfer_in      = |grant;

  // Next-state for the output buffer and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer_in) begin
      out_data_d  = bus.in_data[grant_idx*DWIDTH +: DWIDTH];
      out_valid_d = 1'b1;
      out_sel_d   = grant_idx;
      if (RR == ARB_RR) ptr_d = grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; ptr resets to NCH-1 so the first search begins at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Directed bench: round-robin NCH=4, fixed-priority NCH=4, round-robin NCH=3.
module tb_mux_nto1_arb;

  localparam int DW = 16;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  logic [1:0] rr_ptr, fp_ptr, w3_ptr;

  mux_nto1_arb_if #(.DWIDTH(DW), .NCH(4)) rr_if ();
  mux_nto1_arb_if #(.DWIDTH(DW), .NCH(4)) fp_if ();
  mux_nto1_arb_if #(.DWIDTH(DW), .NCH(3)) w3_if ();

  mux_nto1_arb #(.DWIDTH(DW), .NCH(4), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .bus(rr_if.slave), .dbg_ptr(rr_ptr));
  mux_nto1_arb #(.DWIDTH(DW), .NCH(4), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .bus(fp_if.slave), .dbg_ptr(fp_ptr));
  mux_nto1_arb #(.DWIDTH(DW), .NCH(3), .RR(1)) u_w3 (
    .clk(clk), .rst(rst), .bus(w3_if.slave), .dbg_ptr(w3_ptr));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    rr_if.in_data = '0; rr_if.in_valid = '0; rr_if.out_ready = 1'b1;
    fp_if.in_data = '0; fp_if.in_valid = '0; fp_if.out_ready = 1'b1;
    w3_if.in_data = '0; w3_if.in_valid = '0; w3_if.out_ready = 1'b1;

    // Reset state, and ready held low during reset even with requests.
    #1;
    chk("rst_valid", 32'(rr_if.out_valid), 32'd0);
    chk("rst_data",  32'(rr_if.out_data),  32'd0);
    chk("rst_sel",   32'(rr_if.out_sel),   32'd0);
    chk("rst_ptr",   32'(rr_ptr),          32'd3);
    for (int i = 0; i < 4; i++) rr_if.in_data[i*DW +: DW] = 16'h00A0 + 16'(i);
    rr_if.in_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(rr_if.in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(rr_if.in_ready), 32'h1);

    // Round-robin fairness: all channels valid, consumer always ready.
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_sel",   32'(rr_if.out_sel),   32'(k % 4));
      chk("rr_valid", 32'(rr_if.out_valid), 32'd1);
      chk("rr_data",  32'(rr_if.out_data),  32'h00A0 + 32'(k % 4));
    end

    // Backpressure: load 0xAAAA from ch0, then stall with ch2 waiting.
    rr_if.in_data[0*DW +: DW] = 16'hAAAA;
    rr_if.in_valid = 4'b0001;
    tick();
    chk("bp_load_data", 32'(rr_if.out_data), 32'hAAAA);
    chk("bp_load_ptr",  32'(rr_ptr),         32'd0);
    rr_if.out_ready = 1'b0;
    rr_if.in_data[2*DW +: DW] = 16'h2222;
    rr_if.in_valid = 4'b0100;
    #1;
    chk("bp_ready0", 32'(rr_if.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data",  32'(rr_if.out_data),  32'hAAAA);
      chk("bp_hold_valid", 32'(rr_if.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(rr_if.in_ready),  32'd0);
      chk("bp_hold_ptr",   32'(rr_ptr),          32'd0);
    end
    rr_if.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rr_if.in_ready), 32'b0100);
    tick();
    chk("bp_next_data",  32'(rr_if.out_data),  32'h2222);
    chk("bp_next_valid", 32'(rr_if.out_valid), 32'd1);
    chk("bp_next_sel",   32'(rr_if.out_sel),   32'd2);
    chk("bp_next_ptr",   32'(rr_ptr),          32'd2);
    rr_if.in_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(rr_if.out_valid), 32'd0);
    chk("drain_data",  32'(rr_if.out_data),  32'h2222);
    chk("drain_sel",   32'(rr_if.out_sel),   32'd2);

    // Sparse requests on ch1: beat, idle, beat, idle.
    for (int j = 0; j < 2; j++) begin
      rr_if.in_data[1*DW +: DW] = 16'h1111 + 16'(j);
      rr_if.in_valid = 4'b0010;
      tick();
      chk("sp_valid", 32'(rr_if.out_valid), 32'd1);
      chk("sp_data",  32'(rr_if.out_data),  32'h1111 + 32'(j));
      chk("sp_sel",   32'(rr_if.out_sel),   32'd1);
      chk("sp_ptr",   32'(rr_ptr),          32'd1);
      rr_if.in_valid = 4'b0000;
      tick();
      chk("sp_idle_valid", 32'(rr_if.out_valid), 32'd0);
      chk("sp_idle_ptr",   32'(rr_ptr),          32'd1);
    end

    // Reset mid-stream discards the pending beat without a clock edge.
    rr_if.in_data[1*DW +: DW] = 16'h5555;
    rr_if.in_valid = 4'b0010;
    tick();
    chk("mid_pre_valid", 32'(rr_if.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rr_if.out_valid), 32'd0);
    chk("mid_rst_data",  32'(rr_if.out_data),  32'd0);
    chk("mid_rst_sel",   32'(rr_if.out_sel),   32'd0);
    chk("mid_rst_ptr",   32'(rr_ptr),          32'd3);
    rr_if.in_valid = 4'hF;
    #1;
    chk("mid_rst_ready", 32'(rr_if.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", 32'(rr_if.in_ready), 32'h1);
    tick();
    chk("mid_post_sel", 32'(rr_if.out_sel), 32'd0);
    rr_if.in_valid = 4'b0000;

    // Fixed priority: ch1 beats ch3 until ch1 drops.
    fp_if.in_data[1*DW +: DW] = 16'h0011;
    fp_if.in_data[3*DW +: DW] = 16'h0033;
    fp_if.in_valid = 4'b1010;
    #1;
    chk("fp_ready", 32'(fp_if.in_ready), 32'b0010);
    tick();
    chk("fp_data", 32'(fp_if.out_data), 32'h0011);
    chk("fp_sel",  32'(fp_if.out_sel),  32'd1);
    chk("fp_ptr",  32'(fp_ptr),         32'd3);
    chk("fp_ready_again", 32'(fp_if.in_ready), 32'b0010);
    tick();
    chk("fp_sel_again", 32'(fp_if.out_sel), 32'd1);
    fp_if.in_valid = 4'b1000;
    #1;
    chk("fp_ready_ch3", 32'(fp_if.in_ready), 32'b1000);
    tick();
    chk("fp_data_ch3", 32'(fp_if.out_data), 32'h0033);
    chk("fp_sel_ch3",  32'(fp_if.out_sel),  32'd3);
    fp_if.in_valid = 4'b0000;

    // NCH=3 wrap: get ptr to 2, then requests on ch0/ch1 wrap to ch0.
    w3_if.in_data[0*DW +: DW] = 16'h000A;
    w3_if.in_data[1*DW +: DW] = 16'h000B;
    w3_if.in_data[2*DW +: DW] = 16'h000C;
    w3_if.in_valid = 3'b100;
    tick();
    chk("w3_sel2", 32'(w3_if.out_sel), 32'd2);
    chk("w3_ptr2", 32'(w3_ptr),        32'd2);
    w3_if.in_valid = 3'b011;
    #1;
    chk("w3_wrap_ready", 32'(w3_if.in_ready), 32'b001);
    tick();
    chk("w3_wrap_sel",  32'(w3_if.out_sel),  32'd0);
    chk("w3_wrap_data", 32'(w3_if.out_data), 32'h000A);
    tick();
    chk("w3_sel1",  32'(w3_if.out_sel),  32'd1);
    chk("w3_data1", 32'(w3_if.out_data), 32'h000B);
    tick();
    chk("w3_sel0_again", 32'(w3_if.out_sel), 32'd0);
    w3_if.in_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("w3_rr_sel",   32'(w3_if.out_sel),   32'((k + 1) % 3));
      chk("w3_rr_valid", 32'(w3_if.out_valid), 32'd1);
    end
    w3_if.in_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
